udp_key_ctrl: RTL and testbench

Parametrised key/send controller for the UDP transmit path. Debounces N touch/push keys and produces per-key press events and toggle states, with LED mirrors of the toggle states. Key 0 toggles periodic streaming. Key 1 requests a single frame. A request arbiter issues one-cycle tx_start_en pulses to the UDP transmitter, gated by its busy flag; requests that are dropped are counted.

---
 rtl/udp_key_ctrl_pkg.sv | 13 +
 rtl/udp_key_ctrl_key_debounce.sv | 72 +++++++
 rtl/udp_key_ctrl.sv | 124 ++++++++++++
 tb/tb_udp_key_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_key_ctrl_pkg.sv
// Shared constants and helpers for the UDP key/send controller.
package udp_ctrl_pkg;

  // Key channel roles
  localparam int KEY_STREAM = 0;
  localparam int KEY_SINGLE = 1;

  // Width of a counter that must hold values 0 .. n-1 (at least 1 bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/udp_key_ctrl_key_debounce.sv
// One key channel: 2-flop synchroniser, debounce counter, stable level and
// a registered one-cycle press event on each accepted inactive->active change.
module key_debounce
  import udp_ctrl_pkg::*;
#(
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYC   = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC - 1);
  // Synchroniser resets to the released level so leaving reset is silent
  localparam logic          IDLE_RAW = KEY_ACTIVE_LOW;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          synced_pressed;
  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic          press_reg;

  // Bring the asynchronous key into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= IDLE_RAW;
      sync2_reg <= IDLE_RAW;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Normalise to 1 = pressed
  assign synced_pressed = KEY_ACTIVE_LOW ? ~sync2_reg : sync2_reg;

  // Accept a new level only after DEBOUNCE_CYC consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (synced_pressed == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      stable_reg <= synced_pressed;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Registered press event on the stable rising edge; releases are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d_reg <= 1'b0;
      press_reg    <= 1'b0;
    end else begin
      stable_d_reg <= stable_reg;
      press_reg    <= stable_reg & ~stable_d_reg;
    end
  end

  assign key_level = stable_reg;
  assign key_press = press_reg;

endmodule

// File: rtl/udp_key_ctrl.sv
// Key/send controller for the UDP transmit path: debounced keys with toggle
// states, periodic streaming on key 0, single shot on key 1, and a request
// arbiter that issues frame-start pulses and counts coalesced requests.
module udp_key_ctrl
  import udp_ctrl_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter int PERIOD_CYC     = 50000000,
  parameter int DROP_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                tx_busy,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_event,
  output logic [NUM_KEYS-1:0] sw_state,
  output logic [NUM_KEYS-1:0] led,
  output logic                stream_en,
  output logic                tx_start_en,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int              PW       = cnt_width(PERIOD_CYC);
  localparam logic [PW-1:0]   PER_MAX  = PW'(PERIOD_CYC - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [NUM_KEYS-1:0] sw_state_reg;
  logic [PW-1:0]       period_cnt_reg;
  logic                period_tick;
  logic                pending_reg;
  logic                pending_next;
  logic                tx_start_reg;
  logic                issue;
  logic                set_req;
  logic [DROP_W-1:0]   drop_cnt_reg;
  logic [DROP_W-1:0]   drop_cnt_next;

  // One debouncer per key channel
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
        .DEBOUNCE_CYC   (DEBOUNCE_CYC)
      ) u_key_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (key_in[gi]),
        .key_level (key_level[gi]),
        .key_press (key_event[gi])
      );
    end
  endgenerate

  // Toggle each key's state on the cycle after its press event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_state_reg <= '0;
    end else begin
      sw_state_reg <= sw_state_reg ^ key_event;
    end
  end

  assign sw_state  = sw_state_reg;
  assign led       = sw_state_reg;
  assign stream_en = sw_state_reg[KEY_STREAM];

  // Frame period counter: free-runs while streaming, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_reg <= '0;
    end else if (!stream_en || period_cnt_reg == PER_MAX) begin
      period_cnt_reg <= '0;
    end else begin
      period_cnt_reg <= period_cnt_reg + 1'b1;
    end
  end

  assign period_tick = stream_en && (period_cnt_reg == PER_MAX);

  // Request arbiter: merge set sources, issue when the transmitter is free,
  // and count requests that land on an already pending one
  always_comb begin
    set_req       = 1'b0;
    issue         = 1'b0;
    pending_next  = pending_reg;
    drop_cnt_next = drop_cnt_reg;

    // Key 0 only requests a frame when it is switching streaming on
    set_req = key_event[KEY_SINGLE]
            | (key_event[KEY_STREAM] & ~sw_state_reg[KEY_STREAM])
            | period_tick;
    // tx_start_reg blocks the cycle after a pulse, covering busy rise latency
    issue   = pending_reg & ~tx_busy & ~tx_start_reg;

    if (issue) begin
      pending_next = set_req;
    end else begin
      pending_next = pending_reg | set_req;
      if (set_req && pending_reg && drop_cnt_reg != DROP_MAX) begin
        drop_cnt_next = drop_cnt_reg + 1'b1;
      end
    end
  end

  // Arbiter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= 1'b0;
      tx_start_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      tx_start_reg <= issue;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign tx_start_en = tx_start_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_udp_key_ctrl.sv
// Bench for udp_key_ctrl: a behavioural model checked every cycle, a table of
// directed vectors, hand-written timing/collision sequences and random keys.
module tb_udp_key_ctrl;

  localparam int NK       = 4;
  localparam int D        = 8;
  localparam int P        = 100;
  localparam int DW       = 8;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [NK-1:0] key_in  = '1;
  logic          tx_busy = 1'b0;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_event;
  logic [NK-1:0] sw_state;
  logic [NK-1:0] led;
  logic          stream_en;
  logic          tx_start_en;
  logic [DW-1:0] drop_cnt;

  udp_key_ctrl #(
    .NUM_KEYS       (NK),
    .KEY_ACTIVE_LOW (1'b1),
    .DEBOUNCE_CYC   (D),
    .PERIOD_CYC     (P),
    .DROP_W         (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .tx_busy     (tx_busy),
    .key_level   (key_level),
    .key_event   (key_event),
    .sw_state    (sw_state),
    .led         (led),
    .stream_en   (stream_en),
    .tx_start_en (tx_start_en),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;
  int tx_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // m_hist[k][j]: pressed sample taken j+1 edges ago; the synchroniser makes
  // the debouncer see sample index 1 at the current edge.
  logic [D+1:0]  m_hist [NK];
  logic [NK-1:0] m_stable, m_rose, m_ev, m_sw;
  logic          m_pend, m_tx;
  int            m_age, m_drop;

  task automatic model_reset();
    for (int k = 0; k < NK; k++) m_hist[k] = '0;
    m_stable = '0; m_rose = '0; m_ev = '0; m_sw = '0;
    m_pend = 1'b0; m_tx = 1'b0; m_age = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic [NK-1:0] rose_now, sw_now;
    logic tick, set_req, issue, flip;
    for (int k = 0; k < NK; k++) begin
      // level flips once the last D seen samples all disagree with it
      flip = 1'b1;
      for (int m = 1; m <= D; m++) if (m_hist[k][m] == m_stable[k]) flip = 1'b0;
      rose_now[k] = flip & ~m_stable[k];
      if (flip) m_stable[k] = ~m_stable[k];
      m_hist[k] = {m_hist[k][D:0], ~key_in[k]};
    end
    tick    = m_sw[0] && ((m_age % P) == P - 1);
    set_req = m_ev[1] | (m_ev[0] & ~m_sw[0]) | tick;
    issue   = m_pend & ~tx_busy & ~m_tx;
    if (set_req && m_pend && !issue && m_drop < DROP_MAX) m_drop++;
    m_pend = issue ? set_req : (m_pend | set_req);
    m_tx   = issue;
    m_age  = m_sw[0] ? m_age + 1 : 0;
    sw_now = m_sw ^ m_ev;
    m_ev   = m_rose;
    m_rose = rose_now;
    m_sw   = sw_now;
  endtask

  // Model step and full output comparison on every falling edge
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    check("cycle_outputs",
          {key_level, key_event, sw_state, led, stream_en, tx_start_en, drop_cnt},
          {m_stable, m_ev, m_sw, m_sw, m_sw[0], m_tx, DW'(m_drop)});
    ev_cnt += $countones(key_event);
    tx_cnt += int'(tx_start_en);
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1);
      if (tx_start_en === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic wait_ev(input int k, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1);
      if (key_event[k] === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic wait_stream(input logic v, input int limit);
    for (int i = 0; i < limit && stream_en !== v; i++) cyc(1);
    check("stream_en_wait", stream_en, v);
  endtask

  typedef struct {
    logic [NK-1:0] keys;
    logic          busy;
    int            cycles;
    int            ev;
    int            tx;
    logic [NK-1:0] sw;
    int            drop;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n;
    tbl[0]  = '{4'b1111, 1'b0, 20, 0, 0, 4'b0000, 0};
    tbl[1]  = '{4'b1011, 1'b0,  5, 0, 0, 4'b0000, 0}; // short glitch
    tbl[2]  = '{4'b1111, 1'b0, 20, 0, 0, 4'b0000, 0};
    tbl[3]  = '{4'b1011, 1'b0, 20, 1, 0, 4'b0100, 0}; // key2 press
    tbl[4]  = '{4'b1111, 1'b0, 20, 0, 0, 4'b0100, 0}; // release, no event
    tbl[5]  = '{4'b1011, 1'b0, 20, 1, 0, 4'b0000, 0}; // second press
    tbl[6]  = '{4'b1111, 1'b0, 20, 0, 0, 4'b0000, 0};
    tbl[7]  = '{4'b1101, 1'b0, 20, 1, 1, 4'b0010, 0}; // single shot
    tbl[8]  = '{4'b1111, 1'b0, 20, 0, 0, 4'b0010, 0};
    tbl[9]  = '{4'b1101, 1'b1, 20, 1, 0, 4'b0000, 0}; // single shot, busy
    tbl[10] = '{4'b1111, 1'b1, 10, 0, 0, 4'b0000, 0};
    tbl[11] = '{4'b1111, 1'b0, 10, 0, 1, 4'b0000, 0}; // busy falls

    // Power-on reset
    rst_n = 1'b0; key_in = '1; tx_busy = 1'b0;
    cyc(3);
    check("reset_outputs",
          {key_level, key_event, sw_state, led, stream_en, tx_start_en, drop_cnt}, 0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      key_in = tbl[i].keys; tx_busy = tbl[i].busy;
      ev_cnt = 0; tx_cnt = 0;
      cyc(tbl[i].cycles);
      check($sformatf("vec%0d_events", i), ev_cnt, tbl[i].ev);
      check($sformatf("vec%0d_tx", i), tx_cnt, tbl[i].tx);
      check($sformatf("vec%0d_sw", i), sw_state, tbl[i].sw);
      check($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].drop);
    end

    // Press latency on key 2
    ev_cnt = 0;
    key_in = 4'b1011;
    wait_ev(2, 30, n);
    check("key2_latency", n, 11);
    cyc(1);
    check("key2_sw", sw_state[2], 1'b1);
    check("key2_led", led[2], 1'b1);
    cyc(8);
    check("key2_single_pulse", ev_cnt, 1);
    key_in = 4'b1111;
    cyc(15);

    // Single shot latency and uniqueness
    key_in = 4'b1101;
    wait_tx(30, n);
    check("single_latency", n, 13);
    tx_cnt = 0;
    key_in = 4'b1111;
    cyc(20);
    check("single_once", tx_cnt, 0);

    // Streaming: immediate frame, then one per period (S = toggle edge)
    key_in = 4'b1110;
    wait_tx(30, n);
    check("stream_first", n, 13);
    check("stream_on", stream_en, 1'b1);
    key_in = 4'b1111;
    wait_tx(120, n);
    check("stream_gap", n, P);

    // Key1 event on the same edge as the period tick (S+200)
    cyc(87);
    key_in = 4'b1101; tx_cnt = 0;
    cyc(27);
    check("coll_tick_key1_tx", tx_cnt, 1);
    check("coll_tick_key1_drop", drop_cnt, 0);
    key_in = 4'b1111;
    cyc(72);

    // Tick on the same edge as an issue (S+300): pending survives
    key_in = 4'b1101;
    wait_tx(30, n);
    check("coll_issue_first", n, 13);
    wait_tx(10, n);
    check("coll_issue_gap", n, 2);
    check("coll_issue_drop", drop_cnt, 0);
    key_in = 4'b1111;
    cyc(15);

    // Streaming off: no more frames
    key_in = 4'b1110;
    wait_stream(1'b0, 40);
    key_in = 4'b1111; tx_cnt = 0;
    cyc(300);
    check("stream_off_quiet", tx_cnt, 0);

    // Overrun while busy
    tx_busy = 1'b1;
    key_in = 4'b1110;
    wait_stream(1'b1, 40);
    key_in = 4'b1111; tx_cnt = 0;
    cyc(350);
    check("overrun_drop", drop_cnt, 3);
    check("overrun_held", tx_cnt, 0);
    tx_busy = 1'b0; tx_cnt = 0;
    cyc(40);
    check("overrun_release", tx_cnt, 1);

    // Drop counter saturation
    tx_busy = 1'b1;
    cyc(26000);
    check("drop_saturate", drop_cnt, DROP_MAX);

    // Reset mid-operation with keys pressed and streaming active
    key_in = '0;
    cyc(5);
    rst_n = 1'b0;
    #1;
    check("reset_async",
          {key_level, key_event, sw_state, led, stream_en, tx_start_en, drop_cnt}, 0);
    cyc(3);
    key_in = '1; tx_busy = 1'b0;
    cyc(2);
    rst_n = 1'b1; ev_cnt = 0;
    cyc(20);
    check("reset_release_noev", ev_cnt, 0);

    // Random keys and busy, checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 2) == 0) key_in[k] = ~key_in[k];
      tx_busy = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 24));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
